// File: rtl/hazard5_bus_interface.sv
// Hazard5 AHB-Lite master port: arbitrates the instruction fetch and load/store
// address requests onto one bus, tracks data-phase ownership and routes
// responses (read data, completion, bus error) back to the owning requestor.
module hazard5_bus_interface #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [W_ADDR-1:0] f_addr,
    input  logic              f_size,
    input  logic              f_addr_vld,
    output logic              f_addr_rdy,
    output logic [W_DATA-1:0] f_data,
    output logic              f_data_vld,
    output logic              f_data_err,

    input  logic [W_ADDR-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_write,
    input  logic [W_DATA-1:0] d_wdata,
    input  logic              d_addr_vld,
    output logic              d_addr_rdy,
    output logic [W_DATA-1:0] d_rdata,
    output logic              d_data_vld,
    output logic              d_data_err,

    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic [W_DATA-1:0] ahblm_hrdata
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_F    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    grant_t            grant_s;
    grant_t            grant_r;
    logic              aph_hold_r;
    logic              dph_f_r;
    logic              dph_d_r;
    logic [W_DATA-1:0] hwdata_r;
    logic              err_cancel_s;
    logic              bus_req_s;
    logic              f_acc_s;
    logic              d_acc_s;

    // Fetch size is word/halfword only; encode as AHB HSIZE.
    function automatic logic [2:0] fetch_hsize(input logic size_word);
        return {1'b0, size_word, !size_word};
    endfunction

    // Cancel the pending address during the first cycle of a two-cycle error response.
    assign err_cancel_s = (dph_f_r || dph_d_r) && ahblm_hresp && !ahblm_hready;

    // Arbitration: a stalled address phase keeps its owner, otherwise data beats fetch.
    always_comb begin
        grant_s = GNT_NONE;
        if (aph_hold_r) begin
            grant_s = grant_r;
        end else if (d_addr_vld) begin
            grant_s = GNT_D;
        end else if (f_addr_vld) begin
            grant_s = GNT_F;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Address-phase mux: drive address attributes from the granted requestor.
    always_comb begin
        ahblm_haddr  = {W_ADDR{1'b0}};
        ahblm_hwrite = 1'b0;
        ahblm_hsize  = 3'b000;
        ahblm_hprot  = 4'b0010;
        case (grant_s)
            GNT_F: begin
                ahblm_haddr  = f_addr;
                ahblm_hwrite = 1'b0;
                ahblm_hsize  = fetch_hsize(f_size);
                ahblm_hprot  = 4'b0010;
            end
            GNT_D: begin
                ahblm_haddr  = d_addr;
                ahblm_hwrite = d_write;
                ahblm_hsize  = {1'b0, d_size};
                ahblm_hprot  = 4'b0011;
            end
            default: begin
                ahblm_haddr  = {W_ADDR{1'b0}};
                ahblm_hwrite = 1'b0;
                ahblm_hsize  = 3'b000;
                ahblm_hprot  = 4'b0010;
            end
        endcase
    end

    assign bus_req_s       = (grant_s != GNT_NONE) && !err_cancel_s && !rst;
    assign ahblm_htrans    = bus_req_s ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = hwdata_r;

    assign f_acc_s    = bus_req_s && (grant_s == GNT_F) && ahblm_hready;
    assign d_acc_s    = bus_req_s && (grant_s == GNT_D) && ahblm_hready;
    assign f_addr_rdy = f_acc_s;
    assign d_addr_rdy = d_acc_s;

    assign f_data     = ahblm_hrdata;
    assign d_rdata    = ahblm_hrdata;
    assign f_data_vld = dph_f_r && ahblm_hready && !ahblm_hresp && !rst;
    assign f_data_err = dph_f_r && ahblm_hready &&  ahblm_hresp && !rst;
    assign d_data_vld = dph_d_r && ahblm_hready && !ahblm_hresp && !rst;
    assign d_data_err = dph_d_r && ahblm_hready &&  ahblm_hresp && !rst;

    // Bus state: address hold across stalls, data-phase ownership, store data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aph_hold_r <= 1'b0;
            grant_r    <= GNT_NONE;
            dph_f_r    <= 1'b0;
            dph_d_r    <= 1'b0;
            hwdata_r   <= {W_DATA{1'b0}};
        end else begin
            aph_hold_r <= (ahblm_htrans != HTRANS_IDLE) && !ahblm_hready;
            grant_r    <= grant_s;
            if (ahblm_hready) begin
                dph_f_r <= f_acc_s;
                dph_d_r <= d_acc_s;
            end
            if (d_acc_s && d_write) begin
                hwdata_r <= d_wdata;
            end
        end
    end

endmodule

// File: tb/tb_hazard5_bus_interface.sv
// Directed bench for hazard5_bus_interface: address-phase checks inline,
// data-phase responses checked against a queue of expected completions.
module tb_hazard5_bus_interface;

    logic        clk;
    logic        rst;
    logic [31:0] f_addr;
    logic        f_size;
    logic        f_addr_vld;
    logic        f_addr_rdy;
    logic [31:0] f_data;
    logic        f_data_vld;
    logic        f_data_err;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic        d_write;
    logic [31:0] d_wdata;
    logic        d_addr_vld;
    logic        d_addr_rdy;
    logic [31:0] d_rdata;
    logic        d_data_vld;
    logic        d_data_err;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        hready;
    logic        hresp;
    logic [31:0] hwdata;
    logic [31:0] hrdata;

    hazard5_bus_interface dut (
        .clk             (clk),
        .rst             (rst),
        .f_addr          (f_addr),
        .f_size          (f_size),
        .f_addr_vld      (f_addr_vld),
        .f_addr_rdy      (f_addr_rdy),
        .f_data          (f_data),
        .f_data_vld      (f_data_vld),
        .f_data_err      (f_data_err),
        .d_addr          (d_addr),
        .d_size          (d_size),
        .d_write         (d_write),
        .d_wdata         (d_wdata),
        .d_addr_vld      (d_addr_vld),
        .d_addr_rdy      (d_addr_rdy),
        .d_rdata         (d_rdata),
        .d_data_vld      (d_data_vld),
        .d_data_err      (d_data_err),
        .ahblm_haddr     (haddr),
        .ahblm_hwrite    (hwrite),
        .ahblm_htrans    (htrans),
        .ahblm_hsize     (hsize),
        .ahblm_hburst    (hburst),
        .ahblm_hprot     (hprot),
        .ahblm_hmastlock (hmastlock),
        .ahblm_hready    (hready),
        .ahblm_hresp     (hresp),
        .ahblm_hwdata    (hwdata),
        .ahblm_hrdata    (hrdata)
    );

    typedef struct {
        logic        owner_d;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic owner_d, input logic err, input logic chk_data,
                        input logic [31:0] data);
        exp_t e;
        e.owner_d  = owner_d;
        e.err      = err;
        e.chk_data = chk_data;
        e.data     = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Response monitor: every completion must match the oldest expected entry.
    always @(negedge clk) begin
        int   nresp;
        logic got_d;
        logic got_err;
        exp_t e;
        if (!rst) begin
            nresp = int'(f_data_vld) + int'(f_data_err) + int'(d_data_vld) + int'(d_data_err);
            if (nresp != 0) begin
                chk("resp_onehot", nresp, 1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $error("FAIL sb_unexpected: observed response expected none");
                end else begin
                    e       = exp_q.pop_front();
                    got_d   = d_data_vld || d_data_err;
                    got_err = f_data_err || d_data_err;
                    chk("sb_owner_err", {30'd0, got_d, got_err}, {30'd0, e.owner_d, e.err});
                    if (e.chk_data) begin
                        chk("sb_rdata", got_d ? d_rdata : f_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; hready = 1'b1; hresp = 1'b0; hrdata = 32'd0;
        f_addr = 32'h0000_0000; f_size = 1'b1; f_addr_vld = 1'b1;
        d_addr = 32'h0000_0000; d_size = 2'd2; d_write = 1'b0;
        d_wdata = 32'd0; d_addr_vld = 1'b1;

        // Reset: requests present but bus idle and nothing accepted
        sample();
        chk("rst_htrans", htrans, 2'd0);
        chk("rst_f_rdy", f_addr_rdy, 1'b0);
        chk("rst_d_rdy", d_addr_rdy, 1'b0);
        tick();
        rst = 1'b0; f_addr_vld = 1'b0; d_addr_vld = 1'b0;
        sample();
        chk("idle_htrans", htrans, 2'd0);
        chk("idle_hburst", hburst, 3'd0);
        chk("idle_hmastlock", hmastlock, 1'b0);
        tick();

        // Single word fetch
        f_addr = 32'h100; f_size = 1'b1; f_addr_vld = 1'b1;
        sample();
        chk("f1_htrans", htrans, 2'd2);
        chk("f1_haddr", haddr, 32'h100);
        chk("f1_hsize", hsize, 3'd2);
        chk("f1_hprot", hprot, 4'b0010);
        chk("f1_rdy", f_addr_rdy, 1'b1);
        push(1'b0, 1'b0, 1'b1, 32'hA0A0_0100);
        tick();
        f_addr_vld = 1'b0; hrdata = 32'hA0A0_0100;
        sample();
        chk("f1_vld", f_data_vld, 1'b1);
        chk("f1_htrans_idle", htrans, 2'd0);
        tick();

        // Halfword fetch
        f_addr = 32'h106; f_size = 1'b0; f_addr_vld = 1'b1;
        sample();
        chk("hw_hsize", hsize, 3'd1);
        chk("hw_haddr", haddr, 32'h106);
        chk("hw_rdy", f_addr_rdy, 1'b1);
        push(1'b0, 1'b0, 1'b1, 32'h0000_5A5A);
        tick();
        f_addr_vld = 1'b0; f_size = 1'b1; hrdata = 32'h0000_5A5A;
        sample();
        tick();

        // Contention: store wins, fetch follows
        f_addr = 32'h108; f_addr_vld = 1'b1;
        d_addr = 32'h2000; d_size = 2'd2; d_write = 1'b1; d_wdata = 32'hDEAD_BEEF; d_addr_vld = 1'b1;
        sample();
        chk("ct_d_rdy", d_addr_rdy, 1'b1);
        chk("ct_f_rdy", f_addr_rdy, 1'b0);
        chk("ct_haddr", haddr, 32'h2000);
        chk("ct_hwrite", hwrite, 1'b1);
        chk("ct_hprot", hprot, 4'b0011);
        push(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        d_addr_vld = 1'b0; d_write = 1'b0; hrdata = 32'h1111_2222;
        sample();
        chk("ct_hwdata", hwdata, 32'hDEAD_BEEF);
        chk("ct_d_vld", d_data_vld, 1'b1);
        chk("ct_f_vld_early", f_data_vld, 1'b0);
        chk("ct_f_rdy2", f_addr_rdy, 1'b1);
        chk("ct_haddr2", haddr, 32'h108);
        push(1'b0, 1'b0, 1'b1, 32'h3333_4444);
        tick();
        f_addr_vld = 1'b0; hrdata = 32'h3333_4444;
        sample();
        chk("ct_f_vld", f_data_vld, 1'b1);
        tick();

        // Held address: fetch 0x104 stalled three cycles, load arrives mid-stall
        f_addr = 32'h0FC; f_addr_vld = 1'b1;
        sample();
        chk("hd_first_rdy", f_addr_rdy, 1'b1);
        push(1'b0, 1'b0, 1'b1, 32'hC0DE_00FC);
        tick();
        f_addr = 32'h104; hready = 1'b0;
        d_addr = 32'h2004; d_write = 1'b0; d_size = 2'd2;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) d_addr_vld = 1'b1;
            sample();
            chk("hd_haddr", haddr, 32'h104);
            chk("hd_htrans", htrans, 2'd2);
            chk("hd_hprot", hprot, 4'b0010);
            chk("hd_f_rdy", f_addr_rdy, 1'b0);
            chk("hd_d_rdy", d_addr_rdy, 1'b0);
            tick();
        end
        hready = 1'b1; hrdata = 32'hC0DE_00FC;
        sample();
        chk("hd_rel_f_rdy", f_addr_rdy, 1'b1);
        chk("hd_rel_d_rdy", d_addr_rdy, 1'b0);
        chk("hd_rel_haddr", haddr, 32'h104);
        chk("hd_rel_f_vld", f_data_vld, 1'b1);
        push(1'b0, 1'b0, 1'b1, 32'hC0DE_0104);
        tick();
        f_addr_vld = 1'b0; hrdata = 32'hC0DE_0104;
        sample();
        chk("hd_d_rdy2", d_addr_rdy, 1'b1);
        chk("hd_d_haddr", haddr, 32'h2004);
        push(1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
        tick();
        d_addr_vld = 1'b0; hrdata = 32'h0BAD_F00D;
        sample();
        chk("hd_d_vld", d_data_vld, 1'b1);
        tick();

        // Error response on a load with a fetch pending
        d_addr = 32'h3000; d_write = 1'b0; d_addr_vld = 1'b1;
        sample();
        chk("er_d_rdy", d_addr_rdy, 1'b1);
        push(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        d_addr_vld = 1'b0; f_addr = 32'h10C; f_addr_vld = 1'b1;
        hready = 1'b0; hresp = 1'b1;
        sample();
        chk("er1_htrans", htrans, 2'd0);
        chk("er1_f_rdy", f_addr_rdy, 1'b0);
        chk("er1_d_err", d_data_err, 1'b0);
        tick();
        hready = 1'b1;
        sample();
        chk("er2_d_err", d_data_err, 1'b1);
        chk("er2_f_rdy", f_addr_rdy, 1'b1);
        chk("er2_haddr", haddr, 32'h10C);
        push(1'b0, 1'b0, 1'b1, 32'h7777_010C);
        tick();
        f_addr_vld = 1'b0; hresp = 1'b0; hrdata = 32'h7777_010C;
        sample();
        chk("er3_f_vld", f_data_vld, 1'b1);
        tick();

        // Reset asserted with a fetch data phase outstanding
        f_addr = 32'h200; f_addr_vld = 1'b1;
        sample();
        chk("rs_f_rdy", f_addr_rdy, 1'b1);
        tick();
        rst = 1'b1; hrdata = 32'h5555_5555;
        sample();
        chk("rs_htrans", htrans, 2'd0);
        chk("rs_f_vld", f_data_vld, 1'b0);
        chk("rs_f_rdy_held", f_addr_rdy, 1'b0);
        tick();
        rst = 1'b0; f_addr_vld = 1'b0;
        sample();
        chk("rs_dph_f", dut.dph_f_r, 1'b0);
        chk("rs_dph_d", dut.dph_d_r, 1'b0);
        chk("rs_post_f_vld", f_data_vld, 1'b0);
        chk("rs_post_htrans", htrans, 2'd0);
        tick();

        // Idle bus ignores responses
        hresp = 1'b1;
        sample();
        chk("id_f_err", f_data_err, 1'b0);
        chk("id_d_err", d_data_err, 1'b0);
        tick();
        hresp = 1'b0;
        sample();
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
